// File: rtl/sram_mem_controller.sv
// MEM-stage data memory sequencer: splits each 32-bit access into
// two timed 16-bit accesses on an external asynchronous SRAM.
module sram_mem_controller #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic        sram_we_n,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_i
);

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state;
  state_t      state_nx;
  logic        op;
  logic [3:0]  cnt;
  logic [16:0] word_q;
  logic [31:0] wdata_q;
  logic [17:0] addr_q;
  logic [15:0] dq_q;
  logic [16:0] word;
  logic        req;
  logic        busy;
  logic        last;

  assign word = 17'((address - 32'(BASE_ADDR)) >> 2);
  assign req  = rd_en | wr_en;
  assign busy = (state == LO) || (state == HI);
  assign last = (cnt == LAST);

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    unique case (state)
      IDLE: begin
        ready = ~req;
        if (req) state_nx = LO;
      end
      LO:   if (last) state_nx = HI;
      HI:   if (last) state_nx = DONE;
      DONE: begin
        ready    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Address and data hold their last driven value outside LO/HI.
  always_comb begin
    sram_addr  = addr_q;
    sram_dq_o  = dq_q;
    sram_dq_oe = 1'b0;
    sram_we_n  = 1'b1;
    if (busy) begin
      sram_addr  = {word_q, state == HI};
      sram_dq_o  = (state == HI) ? wdata_q[31:16] : wdata_q[15:0];
      sram_dq_oe = ~op;
      sram_we_n  = ~(~op & (cnt < LAST));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op        <= 1'b0;
      word_q    <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      dq_q      <= '0;
      read_data <= '0;
    end else begin
      state  <= state_nx;
      addr_q <= sram_addr;
      dq_q   <= sram_dq_o;
      if (!busy || state_nx != state) cnt <= '0;
      else cnt <= cnt + 4'd1;
      if (state == IDLE && req) begin
        op      <= rd_en;
        word_q  <= word;
        wdata_q <= write_data;
      end
      if (busy && op && last) begin
        if (state == HI) read_data[31:16] <= sram_dq_i;
        else read_data[15:0] <= sram_dq_i;
      end
    end
  end

endmodule
